crc_control_unit: RTL and testbench
===================================

// Module: crc_control_unit
// PURPOSE
// - Sequencing FSM directly upstream of crc_datapath: drives all its enables/selects from bus-side write/read/reset strobes.
// - Feeds one byte per cycle into the 8-bit-parallel CRC unit.
// - Uses a double buffer (buffer_ff -> byte_ff), so back-to-back word writes sustain 4 cycles/word without bubbles.
// - Produces a bus wait signal (ready) for full-buffer writes and for CRC reads issued while a calculation is in flight.
// PARAMETERS
// - CNT_WIDTH  32  width of byte_cnt; used only when CRC_BYTE_COUNT_EN is defined.
// PORTS
// - clk                 in   1          single clock; everything on posedge.
// - rst                 in   1          synchronous, active-high reset.
// - crc_dr_wr           in   1          bus write to data register this cycle.
// - crc_dr_rd           in   1          bus read of CRC result this cycle.
// - crc_cr_rst          in   1          control-register reset command (abort + reinit).
// - crc_init_wr         in   1          write to init register.
// - size_out            in   2          from datapath: 00 byte, 01 half, 10 word, 11 = word.
// - ready               out  1          0 = insert bus wait state.
// - busy                out  1          buffer_full | (state != IDLE).
// - buffer_en, byte_en, crc_out_en, bypass_byte0, bypass_size, buffer_rst  out  1 each  datapath enables.
// - set_crc_init_sel, clear_crc_init_sel  out  1 each  chaining-flop control.
// - byte_sel            out  2          CRC unit byte mux select.
// - byte_cnt            out  CNT_WIDTH  processed-byte count (see CONFIGURATION).
// BEHAVIOUR
// - Registers:
//   - state: IDLE, BYTE1, BYTE2, BYTE3.
//   - buffer_full: buffer_ff holds an unprocessed word.
//   - rst -> state IDLE, buffer_full 0.
//   - All outputs are combinational from these registers plus the inputs.
//   - Reset/idle output values: every enable 0, byte_sel 00, ready 1, busy 0, byte_cnt 0.
// - load = (state==IDLE) & buffer_full & !crc_cr_rst. In a load cycle:
//   - byte_en=1, bypass_byte0=1, bypass_size=1, byte_sel=00.
//   - crc_out_en=1, set_crc_init_sel=1.
//   - next state = BYTE1 if the bypassed size is half/word, else IDLE.
// - BYTEk (k=1..3):
//   - byte_sel=k, bypass_*=0, crc_out_en=1, set_crc_init_sel=1.
//   - Last byte: k=1 for half, k=3 for word (size taken from size_ff).
//   - Not last: next state BYTEk+1. Last: next state IDLE.
//   - A load in the following IDLE cycle gives zero-bubble back-to-back words.
// - Write handshake:
//   - wr_ok = !buffer_full | load.
//   - buffer_en = crc_dr_wr & wr_ok & !crc_cr_rst.
//   - buffer_full next = buffer_en | (buffer_full & !load).
//   - Simultaneous load and write: the old word moves to byte_ff while the new word enters buffer_ff in the same edge; buffer_full stays 1.
// - ready = !( (crc_dr_wr & !wr_ok) | (crc_dr_rd & busy) ).
//   - A stalled master holds its request; the FSM accepts it once the condition clears.
//   - A read completes only in IDLE with an empty buffer, so crc_out reflects every accepted byte.
// - crc_cr_rst (highest priority, one cycle):
//   - buffer_rst=1, clear_crc_init_sel=1; crc_out_en=0, byte_en=0, buffer_en=0.
//   - state -> IDLE, buffer_full -> 0.
//   - A concurrent write is accepted on the bus (ready=1) but discarded.
//   - Mid-word abort: remaining bytes are dropped.
// - crc_init_wr -> clear_crc_init_sel=1 that cycle.
//   - This overrides set_crc_init_sel inside the datapath; the next byte uses the new init.
// - byte_sel/bypass values outside active cycles are don't-care but driven 0.
// CONFIGURATION
// - `define CRC_BYTE_COUNT_EN:
//   - byte_cnt increments by 1 on every crc_out_en cycle and wraps modulo 2^CNT_WIDTH.
//   - Cleared by rst or crc_cr_rst.
// - Without the macro: byte_cnt is tied to 0 and the counter flops are absent.
// - The port list is identical in both builds.
// TESTING
// - Reset, then word write 0x31323334 (size 10):
//   - byte_en in cycle 1, byte_sel 0,1,2,3 on cycles 1-4, crc_out_en 4 cycles, then IDLE.
//   - crc_out equals the datapath reference CRC of the bytes.
// - Three back-to-back word writes:
//   - 2nd write accepted without wait; 3rd write gets ready=0 for 3 cycles.
//   - 12 consecutive crc_out_en cycles, no bubble.
// - Byte writes 0x41 every cycle: ready always 1, one load per cycle, state never leaves IDLE.
// - Read issued right after a word write: ready=0 until the IDLE-and-empty cycle; then ready=1 and the CRC is final.
// - crc_cr_rst asserted during BYTE2:
//   - buffer_rst=1, clear_crc_init_sel=1, state IDLE, buffer_full 0.
//   - A write issued in the same cycle is dropped.
// - With CRC_BYTE_COUNT_EN: 1 half + 1 word -> byte_cnt=6; crc_cr_rst -> 0; CNT_WIDTH=3 with 9 bytes -> 1.

Source files
------------

// File: rtl/crc_control_unit.sv
// Sequencing FSM for crc_datapath: double-buffered word intake, one byte per cycle into the CRC unit.
// Optional processed-byte counter enabled by `define CRC_BYTE_COUNT_EN (byte_cnt tied to 0 otherwise).
module crc_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 crc_dr_wr,
  input  logic                 crc_dr_rd,
  input  logic                 crc_cr_rst,
  input  logic                 crc_init_wr,
  input  logic [1:0]           size_out,
  output logic                 ready,
  output logic                 busy,
  output logic                 buffer_en,
  output logic                 byte_en,
  output logic                 crc_out_en,
  output logic                 bypass_byte0,
  output logic                 bypass_size,
  output logic                 buffer_rst,
  output logic                 set_crc_init_sel,
  output logic                 clear_crc_init_sel,
  output logic [1:0]           byte_sel,
  output logic [CNT_WIDTH-1:0] byte_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } state_t;

  state_t state;
  logic   buffer_full;
  logic   load;
  logic   active;
  logic   wr_ok;

  always_comb begin
    load               = (state == IDLE) & buffer_full & ~crc_cr_rst;
    active             = (state != IDLE);
    wr_ok              = ~buffer_full | load;
    buffer_en          = crc_dr_wr & wr_ok & ~crc_cr_rst;
    busy               = buffer_full | active;
    // A write colliding with a control reset is acknowledged and then dropped.
    ready              = ~((crc_dr_wr & ~wr_ok & ~crc_cr_rst) | (crc_dr_rd & busy));
    byte_en            = load;
    bypass_byte0       = load;
    bypass_size        = load;
    crc_out_en         = (load | active) & ~crc_cr_rst;
    set_crc_init_sel   = crc_out_en;
    clear_crc_init_sel = crc_cr_rst | crc_init_wr;
    buffer_rst         = crc_cr_rst;
    byte_sel           = '0;
    if (active && !crc_cr_rst)
      byte_sel = state;
  end

  // In BYTEk cycles bypass_size is low, so size_out reflects the word's latched size.
  always_ff @(posedge clk) begin
    if (rst || crc_cr_rst) begin
      state       <= IDLE;
      buffer_full <= 1'b0;
    end else begin
      buffer_full <= buffer_en | (buffer_full & ~load);
      case (state)
        IDLE:    if (load && size_out != 2'b00) state <= BYTE1;
        BYTE1:   state <= size_out[1] ? BYTE2 : IDLE;
        BYTE2:   state <= BYTE3;
        BYTE3:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC_BYTE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || crc_cr_rst)
      cnt_q <= '0;
    else if (crc_out_en)
      cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign byte_cnt = cnt_q;
`else
  assign byte_cnt = '0;
`endif

endmodule

// File: tb/tb_crc_control_unit.sv
// Randomized bench for crc_control_unit against a byte-counting transaction model.
module tb_crc_control_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0, rd = 1'b0, crst = 1'b0, iwr = 1'b0;
  logic [1:0]    wr_size = 2'b00;
  logic [1:0]    size_out;
  logic          ready, busy, buffer_en, byte_en, crc_out_en, bypass_byte0, bypass_size;
  logic          buffer_rst, set_crc_init_sel, clear_crc_init_sel;
  logic [1:0]    byte_sel;
  logic [CW-1:0] byte_cnt;

  crc_control_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .crc_dr_wr(wr), .crc_dr_rd(rd), .crc_cr_rst(crst),
    .crc_init_wr(iwr), .size_out(size_out), .ready(ready), .busy(busy),
    .buffer_en(buffer_en), .byte_en(byte_en), .crc_out_en(crc_out_en),
    .bypass_byte0(bypass_byte0), .bypass_size(bypass_size), .buffer_rst(buffer_rst),
    .set_crc_init_sel(set_crc_init_sel), .clear_crc_init_sel(clear_crc_init_sel),
    .byte_sel(byte_sel), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Datapath size path emulation: buffer_ff size and byte_ff size with bypass mux.
  logic [1:0] dp_buf_size = 2'b00, dp_cur_size = 2'b00;
  assign size_out = bypass_size ? dp_buf_size : dp_cur_size;
  always @(posedge clk) begin
    if (buffer_en) dp_buf_size <= wr_size;
    if (byte_en)   dp_cur_size <= dp_buf_size;
  end

  logic [11:0] obs;
  assign obs = {ready, busy, buffer_en, byte_en, crc_out_en, bypass_byte0, bypass_size,
                buffer_rst, set_crc_init_sel, clear_crc_init_sel, byte_sel};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: a buffered word (byte count) and bytes still to be emitted for the current word.
  bit          m_full = 0;
  int          m_buf_bytes = 1;
  int          m_left = 0;
  int          m_idx = 0;
  int unsigned m_cnt = 0;
  bit          e_load, e_active, e_bufen, e_outen;
  logic [11:0] exp_vec;
  logic [CW-1:0] exp_cnt;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_eval();
    bit wr_ok, e_busy, e_ready;
    logic [1:0] sel;
    e_active = (m_left > 0);
    e_load   = !e_active && m_full && !crst;
    wr_ok    = !m_full || e_load;
    e_bufen  = wr && wr_ok && !crst;
    e_outen  = (e_load || e_active) && !crst;
    e_busy   = m_full || e_active;
    e_ready  = !((wr && !wr_ok && !crst) || (rd && e_busy));
    sel      = (e_active && !crst) ? 2'(m_idx) : 2'b00;
    exp_vec  = {e_ready, e_busy, e_bufen, e_load, e_outen, e_load, e_load,
                crst, e_outen, crst || iwr, sel};
`ifdef CRC_BYTE_COUNT_EN
    exp_cnt = CW'(m_cnt);
`else
    exp_cnt = '0;
`endif
  endtask

  task automatic model_advance();
    if (rst || crst) begin
      m_full = 0; m_left = 0; m_idx = 0; m_cnt = 0;
    end else begin
      if (e_outen) m_cnt = (m_cnt + 1) % (1 << CW);
      if (e_load) begin
        m_left = m_buf_bytes - 1;
        m_idx  = 1;
      end else if (e_active) begin
        m_left--;
        m_idx++;
      end
      m_full = e_bufen || (m_full && !e_load);
      if (e_bufen) m_buf_bytes = nbytes(wr_size);
    end
    cyc++;
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic i,
                       input logic [1:0] s);
    @(negedge clk);
    wr = w; rd = r; crst = c; iwr = i; wr_size = s;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      model_advance();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 2'b00);
    checks++;
    if ({obs, byte_cnt} !== {12'h800, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_idle cyc=%0d got=%h/%0d expected=800/0", cyc, obs, byte_cnt);
    end
    model_advance();
  endtask

  task automatic test_word();
    int n_out = 0;
    logic [7:0] sels = '0;
    for (int k = 0; k < 7; k++) begin
      drive(k == 0, 0, 0, 0, 2'b10);
      checks++;
      if ({obs, byte_cnt} !== {exp_vec, exp_cnt}) begin
        errors++;
        $display("FAIL word cyc=%0d got=%h/%0d expected=%h/%0d", cyc, obs, byte_cnt, exp_vec, exp_cnt);
      end
      if (crc_out_en && n_out < 4) begin
        sels[2*n_out +: 2] = byte_sel;
        n_out++;
      end else if (crc_out_en) n_out++;
      model_advance();
    end
    checks++;
    if (n_out != 4 || sels !== 8'b11_10_01_00) begin
      errors++;
      $display("FAIL word_seq got=%0d sels=%b expected=4 sels=11100100", n_out, sels);
    end
  endtask

  task automatic test_back_to_back();
    int pending = 3, waits = 0, run = 0, best = 0, k = 0;
    while ((pending > 0 || busy) && k < 40) begin
      drive(pending > 0, 0, 0, 0, 2'b10);
      checks++;
      if ({obs, byte_cnt} !== {exp_vec, exp_cnt}) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%h/%0d expected=%h/%0d", cyc, obs, byte_cnt, exp_vec, exp_cnt);
      end
      if (pending > 0) begin
        if (ready) pending--; else waits++;
      end
      run  = crc_out_en ? run + 1 : 0;
      best = (run > best) ? run : best;
      model_advance();
      k++;
    end
    checks++;
    if (waits != 3 || best != 12 || k >= 40) begin
      errors++;
      $display("FAIL b2b_summary got waits=%0d run=%0d cycles=%0d expected waits=3 run=12", waits, best, k);
    end
  endtask

  task automatic test_byte_stream();
    int loads = 0, stalls = 0, active = 0;
    for (int k = 0; k < 17; k++) begin
      drive(k < 16, 0, 0, 0, 2'b00);
      checks++;
      if ({obs, byte_cnt} !== {exp_vec, exp_cnt}) begin
        errors++;
        $display("FAIL bytes cyc=%0d got=%h/%0d expected=%h/%0d", cyc, obs, byte_cnt, exp_vec, exp_cnt);
      end
      if (byte_en) loads++;
      if (!ready) stalls++;
      if (byte_sel != 2'b00) active++;
      model_advance();
    end
    checks++;
    if (loads != 16 || stalls != 0 || active != 0) begin
      errors++;
      $display("FAIL bytes_summary got loads=%0d stalls=%0d nonidle=%0d expected 16/0/0", loads, stalls, active);
    end
  endtask

  task automatic test_read_wait();
    int waits = 0, k = 0;
    bit done = 0;
    drive(1, 0, 0, 0, 2'b10);
    model_advance();
    while (!done && k < 20) begin
      drive(0, 1, 0, 0, 2'b00);
      checks++;
      if ({obs, byte_cnt} !== {exp_vec, exp_cnt}) begin
        errors++;
        $display("FAIL read cyc=%0d got=%h/%0d expected=%h/%0d", cyc, obs, byte_cnt, exp_vec, exp_cnt);
      end
      if (ready) done = 1; else waits++;
      model_advance();
      k++;
    end
    checks++;
    if (waits != 4 || !done) begin
      errors++;
      $display("FAIL read_wait got waits=%0d done=%0d expected waits=4 done=1", waits, done);
    end
  endtask

  task automatic test_abort();
    int k = 0;
    drive(1, 0, 0, 0, 2'b10);
    model_advance();
    while (!(m_left > 0 && m_idx == 2) && k < 10) begin
      drive(0, 0, 0, 0, 2'b00);
      model_advance();
      k++;
    end
    drive(1, 0, 1, 0, 2'b10);
    checks++;
    if ({obs, byte_cnt} !== {exp_vec, exp_cnt} || obs !== 12'hC14 || k >= 10) begin
      errors++;
      $display("FAIL abort cyc=%0d got=%h expected=%h/c14", cyc, obs, exp_vec);
    end
    model_advance();
    drive(0, 0, 0, 0, 2'b00);
    checks++;
    if ({obs, byte_cnt} !== {exp_vec, exp_cnt} || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after cyc=%0d got=%h/%0d expected=%h/%0d", cyc, obs, byte_cnt, exp_vec, exp_cnt);
    end
    model_advance();
  endtask

  task automatic test_init();
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, 0, 0, k == 2, 2'b01);
      checks++;
      if ({obs, byte_cnt} !== {exp_vec, exp_cnt}) begin
        errors++;
        $display("FAIL init cyc=%0d got=%h/%0d expected=%h/%0d", cyc, obs, byte_cnt, exp_vec, exp_cnt);
      end
      model_advance();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 15) == 0, 2'($urandom));
      checks++;
      if ({obs, byte_cnt} !== {exp_vec, exp_cnt}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h/%0d expected=%h/%0d", cyc, obs, byte_cnt, exp_vec, exp_cnt);
      end
      model_advance();
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_back_to_back();
    test_byte_stream();
    test_read_wait();
    test_abort();
    test_init();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
